// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter: wrap or saturate at limits, clear, load, prescaled enable.
// q and rollover are registered (1 edge after clr/load/step); tc is combinational from q and up.
// No backpressure: every edge performs exactly one of clear, load, count or hold.
module mod_updown_counter #(
   parameter int              WIDTH     = 4,
   parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
   parameter int              PRESCALE  = 1,
   parameter bit              SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             rollover
);

   localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAXV = MAX_VALUE[WIDTH-1:0];

   // High on the enabled edge that completes a prescale period.
   logic ps_last;
   logic step;
   logic at_limit;

   assign step     = en && ps_last;
   assign at_limit = up ? (q == MAXV) : (q == '0);

   generate
      if (PRESCALE == 1) begin : g_nops
         // Every enabled edge is a step; no prescale state is needed.
         assign ps_last = 1'b1;
      end else begin : g_ps
         logic [PSW-1:0] ps;
         assign ps_last = (ps == PSW'(PRESCALE - 1));

         // Prescale counter: restarts on reset/clear/load, advances on enabled edges.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ps <= '0;
            end else if (clr || load) begin
               ps <= '0;
            end else if (en) begin
               ps <= ps_last ? '0 : ps + 1'b1;
            end
         end
      end
   endgenerate

   // Count register and rollover pulse, priority clr > load > step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q        <= '0;
         rollover <= 1'b0;
      end else if (clr) begin
         q        <= '0;
         rollover <= 1'b0;
      end else if (load) begin
         q        <= (load_value > MAXV) ? MAXV : load_value;
         rollover <= 1'b0;
      end else if (step) begin
         rollover <= at_limit;
         if (at_limit) begin
            // At a limit: wrap to the opposite end, or hold when saturating.
            if (SATURATE == 1'b0) begin
               q <= up ? '0 : MAXV;
            end
         end else begin
            q <= up ? q + 1'b1 : q - 1'b1;
         end
      end else begin
         rollover <= 1'b0;
      end
   end

   // Terminal count follows the direction input with no latency.
   assign tc = at_limit;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four configurations checked against an arithmetic model.
// Model and DUT outputs compared on every falling edge, plus hand-computed literal checks.
// Inputs change 1 time unit after each rising edge.
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   logic [3:0] rst, clr, load, en, up;
   logic [3:0] lv [4];
   logic [3:0] q [4];
   logic [3:0] tc, ro;

   wire [31:0] m_q [4];
   wire [3:0]  m_tc, m_ro;

   int n_cmp = 0;
   int n_mis = 0;
   int phase = 0;
   int kk    = 0;

   always #5 clk = ~clk;

   // Instance 0: defaults (wrap, 0..15, no prescale)
   mod_updown_counter u0 (.clk(clk), .reset(rst[0]), .clr(clr[0]), .load(load[0]),
      .load_value(lv[0]), .en(en[0]), .up(up[0]), .q(q[0]), .tc(tc[0]), .rollover(ro[0]));
   // Instance 1: modulus 10
   mod_updown_counter #(.MAX_VALUE(9)) u1 (.clk(clk), .reset(rst[1]), .clr(clr[1]),
      .load(load[1]), .load_value(lv[1]), .en(en[1]), .up(up[1]), .q(q[1]), .tc(tc[1]),
      .rollover(ro[1]));
   // Instance 2: prescale by 3
   mod_updown_counter #(.PRESCALE(3)) u2 (.clk(clk), .reset(rst[2]), .clr(clr[2]),
      .load(load[2]), .load_value(lv[2]), .en(en[2]), .up(up[2]), .q(q[2]), .tc(tc[2]),
      .rollover(ro[2]));
   // Instance 3: saturating, 0..12
   mod_updown_counter #(.MAX_VALUE(12), .SATURATE(1'b1)) u3 (.clk(clk), .reset(rst[3]),
      .clr(clr[3]), .load(load[3]), .load_value(lv[3]), .en(en[3]), .up(up[3]), .q(q[3]),
      .tc(tc[3]), .rollover(ro[3]));

   // Behavioural model per instance: count value kept as a plain integer in 0..MX.
   for (genvar g = 0; g < 4; g++) begin : g_m
      localparam int MX = (g == 1) ? 9 : (g == 3) ? 12 : 15;
      localparam int PR = (g == 2) ? 3 : 1;
      localparam bit SA = (g == 3);
      int mq  = 0;
      int mps = 0;
      bit mro = 1'b0;

      always @(posedge clk or posedge rst[g]) begin
         if (rst[g]) begin
            mq = 0; mps = 0; mro = 1'b0;
         end else if (clr[g]) begin
            mq = 0; mps = 0; mro = 1'b0;
         end else if (load[g]) begin
            mq = (int'(lv[g]) > MX) ? MX : int'(lv[g]);
            mps = 0; mro = 1'b0;
         end else if (en[g]) begin
            mps = mps + 1;
            mro = 1'b0;
            if (mps == PR) begin
               mps = 0;
               if (up[g]) begin
                  mro = (mq == MX);
                  mq  = SA ? ((mq + 1 > MX) ? MX : mq + 1) : (mq + 1) % (MX + 1);
               end else begin
                  mro = (mq == 0);
                  mq  = SA ? ((mq == 0) ? 0 : mq - 1) : (mq + MX) % (MX + 1);
               end
            end
         end else begin
            mro = 1'b0;
         end
      end

      assign m_q[g]  = mq;
      assign m_tc[g] = up[g] ? (mq == MX) : (mq == 0);
      assign m_ro[g] = mro;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s at t=%0t: got %0d, need %0d", nm, $time, act, exp);
      end
   endtask

   // Single compare process: model vs DUT every cycle, plus literal pins at chosen edges.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("q%0d_model", i), int'(q[i]), int'(m_q[i]));
         chk($sformatf("tc%0d_model", i), int'(tc[i]), int'(m_tc[i]));
         chk($sformatf("ro%0d_model", i), int'(ro[i]), int'(m_ro[i]));
      end
      if (phase == 0) begin
         chk("reset_q0", int'(q[0]), 0);
         chk("reset_tc0_up", int'(tc[0]), 0);
         chk("reset_tc1_down", int'(tc[1]), 1);
         chk("reset_ro", int'(ro), 0);
      end else if (phase == 1) begin
         case (kk)
            1:  begin chk("mod10_wrap_q", int'(q[1]), 9); chk("mod10_wrap_ro", int'(ro[1]), 1); end
            2:  chk("ps3_hold_q", int'(q[2]), 0);
            3:  chk("ps3_step1_q", int'(q[2]), 1);
            4:  chk("ps3_after4_q", int'(q[2]), 1);
            8:  chk("ps3_step2_q", int'(q[2]), 2);
            10: begin chk("mod10_zero_q", int'(q[1]), 0); chk("mod10_zero_tc", int'(tc[1]), 1); end
            11: begin
               chk("ps3_step3_q", int'(q[2]), 3);
               chk("mod10_wrap2_q", int'(q[1]), 9);
               chk("mod10_wrap2_ro", int'(ro[1]), 1);
            end
            15: begin chk("def_max_q", int'(q[0]), 15); chk("def_max_tc", int'(tc[0]), 1); end
            16: begin
               chk("def_wrap_q", int'(q[0]), 0);
               chk("def_wrap_ro", int'(ro[0]), 1);
               chk("def_wrap_tc", int'(tc[0]), 0);
            end
            17: begin chk("def_next_q", int'(q[0]), 1); chk("def_next_ro", int'(ro[0]), 0); end
            default: ;
         endcase
      end else if (phase == 2) begin
         case (kk)
            1: begin
               chk("load7_q", int'(q[1]), 7);
               chk("load6_q", int'(q[2]), 6);
               chk("sat_load11_q", int'(q[3]), 11);
            end
            2: begin
               chk("prio_clr_q", int'(q[1]), 0);
               chk("ps_partial_q", int'(q[2]), 6);
               chk("sat_step1_q", int'(q[3]), 12);
               chk("sat_step1_ro", int'(ro[3]), 0);
               chk("sat_step1_tc", int'(tc[3]), 1);
            end
            3: begin
               chk("load_clamp_q", int'(q[1]), 9);
               chk("async_reset_q", int'(q[2]), 0);
               chk("sat_step2_q", int'(q[3]), 12);
               chk("sat_step2_ro", int'(ro[3]), 1);
            end
            4: begin
               chk("sat_step3_q", int'(q[3]), 12);
               chk("sat_step3_ro", int'(ro[3]), 1);
            end
            5: begin
               chk("post_reset_e2_q", int'(q[2]), 0);
               chk("sat_down_q", int'(q[3]), 11);
               chk("sat_down_ro", int'(ro[3]), 0);
            end
            6: chk("post_reset_e3_q", int'(q[2]), 1);
            default: ;
         endcase
      end
   end

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 4'hF; clr = '0; load = '0; en = '0; up = 4'b1101;
      for (int i = 0; i < 4; i++) lv[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = '0;
      phase = 1; kk = 0;

      // Phase 1: free counting on instances 0..2 (2 has an enable gap at edges 5,6).
      for (int k = 1; k <= 17; k++) begin
         en[0] = 1'b1; up[0] = 1'b1;
         en[1] = 1'b1; up[1] = 1'b0;
         en[2] = (k <= 4) || (k >= 7 && k <= 11); up[2] = 1'b1;
         en[3] = 1'b0;
         edge_step();
         kk = k;
      end
      en = '0;
      @(negedge clk);
      #1;
      phase = 2; kk = 0;

      // Phase 2: priority/clamp, partial prescale with async reset, saturation.
      for (int k = 1; k <= 6; k++) begin
         clr = '0; load = '0; en = '0;
         case (k)
            1: begin
               load[1] = 1'b1; lv[1] = 4'd7;
               load[2] = 1'b1; lv[2] = 4'd6;
               load[3] = 1'b1; lv[3] = 4'd11;
            end
            2: begin
               clr[1] = 1'b1; load[1] = 1'b1; lv[1] = 4'd5; en[1] = 1'b1;
               en[2] = 1'b1; up[2] = 1'b1;
               en[3] = 1'b1; up[3] = 1'b1;
            end
            3: begin load[1] = 1'b1; lv[1] = 4'd14; en[3] = 1'b1; end
            4: begin en[2] = 1'b1; en[3] = 1'b1; end
            5: begin en[2] = 1'b1; en[3] = 1'b1; up[3] = 1'b0; end
            default: en[2] = 1'b1;
         endcase
         edge_step();
         kk = k;
         if (k == 3) begin
            #2 rst[2] = 1'b1;
            #1 rst[2] = 1'b0;
         end
      end
      clr = '0; load = '0; en = '0;
      @(negedge clk);
      #1;
      phase = 3;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
